// File: rtl/cv32e40s_glitch_pkg.sv
// Shared types for the lockstep glitch detector.
// State encoding and alert widths used by the detector and its bench.
package cv32e40s_glitch_pkg;

  typedef enum logic [1:0] {
    GD_MONITOR = 2'd0,
    GD_SUSPECT = 2'd1,
    GD_FAULT   = 2'd2
  } gd_state_e;

  localparam int unsigned GD_STATE_W = 2;
  localparam int unsigned GD_ALERT_W = 1;

endpackage

// File: rtl/cv32e40s_lockstep_delay.sv
// Skew line for the master bundle: a DEPTH-stage shift register.
// DEPTH of zero collapses to a wire.
module cv32e40s_lockstep_delay #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign q_o = d_i;
    end else begin : g_line
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift every cycle; reset clears all stages
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/cv32e40s_glitch_detector.sv
// Lockstep comparator: delayed master vs shadow bundle.
// Transient mismatches count as minor; a run of them latches a fault.
module cv32e40s_glitch_detector
  import cv32e40s_glitch_pkg::*;
#(
  parameter int unsigned BIT_LENGTH = 32,
  parameter int unsigned DELAY      = 2,
  parameter int unsigned THRESHOLD  = 3,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  valid_in,
  input  logic [BIT_LENGTH-1:0] master_in,
  input  logic [BIT_LENGTH-1:0] shadow_in,
  input  logic                  clear_req,
  output logic                  clear_ack,
  output logic                  alert_minor,
  output logic                  alert_major,
  output logic [BIT_LENGTH-1:0] syndrome,
  output logic [CNT_WIDTH-1:0]  transient_cnt,
  output gd_state_e             state_o
);

  localparam int unsigned CW = $clog2(THRESHOLD + 1);
  localparam logic [CW-1:0] THR_C = CW'(THRESHOLD);

  logic [BIT_LENGTH:0]   skew_in;
  logic [BIT_LENGTH:0]   skew_out;
  logic                  valid_d;
  logic [BIT_LENGTH-1:0] master_d;
  logic [BIT_LENGTH-1:0] diff;
  logic                  cmp_vld;
  logic                  mism;
  logic                  clr_edge;

  gd_state_e             state_q, state_d;
  logic [CW-1:0]         consec_q, consec_d;
  logic [BIT_LENGTH-1:0] syn_q, syn_d;
  logic [CNT_WIDTH-1:0]  tcnt_q, tcnt_d;
  logic                  minor_q, minor_d;
  logic                  ack_q;
  logic                  clr_q;

  assign skew_in = {valid_in, master_in};

  cv32e40s_lockstep_delay #(
    .WIDTH (BIT_LENGTH + 1),
    .DEPTH (DELAY)
  ) u_skew (
    .clk   (clk),
    .reset (reset),
    .d_i   (skew_in),
    .q_o   (skew_out)
  );

  assign valid_d  = skew_out[BIT_LENGTH];
  assign master_d = skew_out[BIT_LENGTH-1:0];
  assign diff     = master_d ^ shadow_in;
  assign cmp_vld  = enable & valid_d;
  assign mism     = cmp_vld & (|diff);
  assign clr_edge = clear_req & ~clr_q;

  // Next state: clear dominates, then episode tracking per state
  always_comb begin
    state_d  = state_q;
    consec_d = consec_q;
    syn_d    = syn_q;
    tcnt_d   = tcnt_q;
    minor_d  = 1'b0;
    if (clr_edge) begin
      state_d  = GD_MONITOR;
      consec_d = '0;
      syn_d    = '0;
    end else begin
      unique case (state_q)
        GD_MONITOR: begin
          if (mism) begin
            consec_d = CW'(1);
            syn_d    = diff;
            minor_d  = 1'b1;
            state_d  = (THRESHOLD == 1) ? GD_FAULT
                                        : GD_SUSPECT;
          end
        end
        GD_SUSPECT: begin
          if (mism) begin
            consec_d = consec_q + CW'(1);
            if (consec_d == THR_C) begin
              state_d = GD_FAULT;
            end
          end else if (cmp_vld) begin
            state_d  = GD_MONITOR;
            consec_d = '0;
            if (tcnt_q != '1) begin
              tcnt_d = tcnt_q + CNT_WIDTH'(1);
            end
          end
        end
        GD_FAULT: begin
          state_d = GD_FAULT;
        end
        default: begin
          state_d = GD_MONITOR;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= GD_MONITOR;
      consec_q <= '0;
      syn_q    <= '0;
      tcnt_q   <= '0;
      minor_q  <= 1'b0;
      ack_q    <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
      syn_q    <= syn_d;
      tcnt_q   <= tcnt_d;
      minor_q  <= minor_d;
      ack_q    <= clr_edge;
      clr_q    <= clear_req;
    end
  end

  assign clear_ack     = ack_q;
  assign alert_minor   = minor_q;
  assign alert_major   = (state_q == GD_FAULT);
  assign syndrome      = syn_q;
  assign transient_cnt = tcnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_cv32e40s_glitch_detector.sv
// Bench for the lockstep glitch detector.
// Directed episodes plus random traffic against a behavioural model.
module tb_cv32e40s_glitch_detector;
  import cv32e40s_glitch_pkg::*;

  localparam int BL = 32;
  localparam int DL = 2;
  localparam int TH = 3;
  localparam int CW = 2;
  localparam int TMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          valid_in = 1'b0;
  logic [BL-1:0] master_in = '0;
  logic [BL-1:0] shadow_in = '0;
  logic          clear_req = 1'b0;
  logic          clear_ack;
  logic          alert_minor;
  logic          alert_major;
  logic [BL-1:0] syndrome;
  logic [CW-1:0] transient_cnt;
  gd_state_e     state_o;

  int vectors = 0;
  int errors  = 0;

  // model: delayed stream history (index 0 newest) and episode view
  bit            hv [DL];
  logic [BL-1:0] hm [DL];
  int            m_state = 0;  // 0 monitor, 1 suspect, 2 fault
  int            m_run   = 0;
  int            m_tc    = 0;
  logic [BL-1:0] m_syn   = '0;
  bit            m_minor = 0;
  bit            m_ack   = 0;
  bit            m_prev  = 0;

  always #5 clk = ~clk;

  cv32e40s_glitch_detector #(
    .BIT_LENGTH (BL),
    .DELAY      (DL),
    .THRESHOLD  (TH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .valid_in      (valid_in),
    .master_in     (master_in),
    .shadow_in     (shadow_in),
    .clear_req     (clear_req),
    .clear_ack     (clear_ack),
    .alert_minor   (alert_minor),
    .alert_major   (alert_major),
    .syndrome      (syndrome),
    .transient_cnt (transient_cnt),
    .state_o       (state_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit en,
                       input bit vld, input logic [BL-1:0] m,
                       input logic [BL-1:0] sh, input bit clr);
    bit            dv;
    logic [BL-1:0] dm;
    bit            edge_seen;
    bit            cv;
    bit            mis;
    if (rst) begin
      for (int i = 0; i < DL; i++) begin
        hv[i] = 0;
        hm[i] = '0;
      end
      m_state = 0; m_run = 0; m_tc = 0; m_syn = '0;
      m_minor = 0; m_ack = 0; m_prev = 0;
      return;
    end
    dv = hv[DL-1];
    dm = hm[DL-1];
    for (int i = DL - 1; i > 0; i--) begin
      hv[i] = hv[i-1];
      hm[i] = hm[i-1];
    end
    hv[0] = vld;
    hm[0] = m;
    edge_seen = clr && !m_prev;
    m_prev = clr;
    m_ack = edge_seen;
    m_minor = 0;
    cv  = en && dv;
    mis = cv && (dm != sh);
    if (edge_seen) begin
      m_state = 0; m_run = 0; m_syn = '0;
    end else if (m_state == 0) begin
      if (mis) begin
        m_run = 1;
        m_syn = dm ^ sh;
        m_minor = 1;
        m_state = (m_run >= TH) ? 2 : 1;
      end
    end else if (m_state == 1) begin
      if (mis) begin
        m_run = m_run + 1;
        if (m_run >= TH) m_state = 2;
      end else if (cv) begin
        m_state = 0;
        m_run = 0;
        if (m_tc < TMAX) m_tc = m_tc + 1;
      end
    end
  endtask

  // one cycle: drive, clock, model, compare all outputs
  task automatic step(input bit rst, input bit en,
                      input bit vld, input logic [BL-1:0] mask,
                      input bit clr);
    logic [BL-1:0] m;
    logic [BL-1:0] sh;
    m = $urandom;
    if (hv[DL-1]) sh = hm[DL-1] ^ mask;
    else sh = $urandom;
    reset = rst; enable = en; valid_in = vld;
    master_in = m; shadow_in = sh; clear_req = clr;
    @(posedge clk);
    model(rst, en, vld, m, sh, clr);
    @(negedge clk);
    check("state", 32'(state_o), 32'(m_state));
    check("minor", 32'(alert_minor), 32'(m_minor));
    check("major", 32'(alert_major), 32'(m_state == 2));
    check("syndrome", syndrome, m_syn);
    check("tcnt", 32'(transient_cnt), 32'(m_tc));
    check("ack", 32'(clear_ack), 32'(m_ack));
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, '0, 0);
  endtask

  initial begin
    logic [BL-1:0] g;
    bit            gv [9];
    bit            gg [9];
    g = 32'h0000_0010;
    gv = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
    gg = '{0, 0, 1, 1, 1, 1, 1, 1, 1};

    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    clean(100);
    // single glitch then recovery
    step(0, 1, 1, g, 0);
    clean(4);
    // persistent run to fault
    step(0, 1, 1, g, 0);
    step(0, 1, 1, g, 0);
    step(0, 1, 1, g, 0);
    clean(5);
    // clear, held request
    step(0, 1, 1, '0, 1);
    step(0, 1, 1, '0, 1);
    step(0, 1, 1, '0, 1);
    step(0, 1, 1, '0, 0);
    clean(2);
    // gapped run
    for (int i = 0; i < 9; i++) step(0, 1, gv[i], gg[i] ? g : '0, 0);
    clean(3);
    step(0, 1, 1, '0, 1);
    step(0, 1, 1, '0, 0);
    clean(2);
    // clear edge coinciding with mismatch
    step(0, 1, 1, g, 1);
    step(0, 1, 1, '0, 0);
    clean(2);
    // enable low holds a suspect episode
    step(0, 1, 1, 32'h8000_0001, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, g, 0);
    clean(3);
    // saturation from zero
    step(1, 0, 0, '0, 0);
    clean(3);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 1, 32'h1 << k, 0);
      clean(2);
    end
    // reset while suspect
    step(0, 1, 1, g, 0);
    step(1, 1, 1, '0, 0);
    clean(3);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [BL-1:0] mk;
      int r;
      r = $urandom_range(0, 99);
      mk = (r < 15) ? (32'h1 << $urandom_range(0, 31)) : '0;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 4) != 0,
           mk,
           $urandom_range(0, 19) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
